// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;
  localparam int DIV_WIDTH = 8;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_restoring_divider_if.sv
// Operand/result handshake bundle for seq_restoring_divider.
interface seq_restoring_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic                   in_valid;
  logic                   in_ready;
  logic [2*WIDTH-1:0]     dividend;
  logic [WIDTH-1:0]       divisor;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       quotient;
  logic [WIDTH-1:0]       remainder;
  logic                   err;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, err
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, err
  );
endinterface

// File: rtl/seq_restoring_divider_step.sv
// One combinational restoring-division step; the subtractor borrow doubles as the compare.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   r_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_out,
  output logic             q_bit
);
  logic [WIDTH:0]   r_shift;
  logic [WIDTH+1:0] diff;

  assign r_shift = {r_in[WIDTH-1:0], bit_in};
  assign diff    = {1'b0, r_shift} - {2'b00, divisor};
  // a set bit shifted out of R already guarantees R >= divisor
  assign q_bit   = r_in[WIDTH] | ~diff[WIDTH+1];
  assign r_out   = q_bit ? diff[WIDTH:0] : r_shift;
endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Optional macro DIV_OVF_CHECK_EN: flag divide-by-zero / quotient overflow at accept.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operation
// RUN   | one restoring step per cycle, WIDTH steps total
// DONE  | out_valid high, result held until out_ready
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_restoring_divider_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] div_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             err_q;

  logic [WIDTH:0]   r_nxt;
  logic             q_bit;
  logic             accept;
  logic             ovf;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in    (r_q),
    .bit_in  (sreg_q[WIDTH-1]),
    .divisor (div_q),
    .r_out   (r_nxt),
    .q_bit   (q_bit)
  );

  assign accept = bus.in_valid && in_ready_q;

`ifdef DIV_OVF_CHECK_EN
  assign ovf = (bus.divisor == '0) || (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor);
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      r_q         <= '0;
      sreg_q      <= '0;
      quot_q      <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            div_q      <= bus.divisor;
            sreg_q     <= bus.dividend[WIDTH-1:0];
            in_ready_q <= 1'b0;
            if (ovf) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              err_q       <= 1'b1;
              quot_q      <= '1;
              r_q         <= {1'b0, bus.dividend[WIDTH-1:0]};
            end else begin
              state <= RUN;
              r_q   <= {1'b0, bus.dividend[2*WIDTH-1:WIDTH]};
              cnt_q <= CW'(WIDTH - 1);
            end
          end
        end
        RUN: begin
          r_q    <= r_nxt;
          sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
          quot_q <= {quot_q[WIDTH-2:0], q_bit};
          if (cnt_q == '0) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            err_q       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = r_q[WIDTH-1:0];
  assign bus.err       = err_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and randomized-legal checks for seq_restoring_divider (WIDTH=8).
module tb_seq_restoring_divider;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  seq_restoring_divider_if #(.WIDTH(8)) bus ();

  seq_restoring_divider #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // lat counts rising edges after the accepting edge until out_valid is seen
  task automatic do_op(input logic [15:0] dd, input logic [7:0] dv, input int hold,
                       output logic [7:0] q, output logic [7:0] r, output logic e,
                       output int lat);
    bit seen;
    @(negedge clk);
    check("pre_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.dividend  = dd;
    bus.divisor   = dv;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    #1;
    // keep presenting junk; it must be ignored outside IDLE
    bus.dividend = 16'hFFFF;
    bus.divisor  = 8'd1;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    check("out_valid_seen", 32'(seen), 32'd1);
    q = bus.quotient;
    r = bus.remainder;
    e = bus.err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_quotient", 32'(bus.quotient), 32'(q));
      check("hold_remainder", 32'(bus.remainder), 32'(r));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_err", 32'(bus.err), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0]  q, r, dv, eq, er;
    logic [15:0] dd;
    logic        e;
    int          lat;

    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;

    do_op(16'd143, 8'd11, 0, q, r, e, lat);
    check("143_11_q", 32'(q), 32'd13);
    check("143_11_r", 32'(r), 32'd0);
    check("143_11_lat", 32'(lat), 32'd8);
    check("143_11_err", 32'(e), 32'd0);

    do_op(16'd65025, 8'd255, 0, q, r, e, lat);
    check("65025_255_q", 32'(q), 32'd255);
    check("65025_255_r", 32'(r), 32'd0);
    check("65025_255_lat", 32'(lat), 32'd8);

    do_op(16'd1000, 8'd7, 5, q, r, e, lat);
    check("1000_7_q", 32'(q), 32'd142);
    check("1000_7_r", 32'(r), 32'd6);
    check("1000_7_err", 32'(e), 32'd0);

`ifdef DIV_OVF_CHECK_EN
    do_op(16'h1234, 8'h00, 2, q, r, e, lat);
    check("div0_err", 32'(e), 32'd1);
    check("div0_q", 32'(q), 32'hFF);
    check("div0_r", 32'(r), 32'h34);
    check("div0_lat", 32'(lat), 32'd0);
    do_op(16'h1234, 8'h10, 0, q, r, e, lat);
    check("ovf_err", 32'(e), 32'd1);
    check("ovf_q", 32'(q), 32'hFF);
    check("ovf_r", 32'(r), 32'h34);
    check("ovf_lat", 32'(lat), 32'd0);
`endif

    // reset in the middle of RUN
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 16'd143;
    bus.divisor  = 8'd11;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrun_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrun_rst_quotient", 32'(bus.quotient), 32'd0);
    check("midrun_rst_remainder", 32'(bus.remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'd100, 8'd9, 1, q, r, e, lat);
    check("100_9_q", 32'(q), 32'd11);
    check("100_9_r", 32'(r), 32'd1);
    check("100_9_lat", 32'(lat), 32'd8);

    for (int k = 0; k < 20; k++) begin
      dv = 8'($urandom_range(1, 255));
      eq = 8'($urandom_range(0, 255));
      er = 8'($urandom_range(0, int'(dv) - 1));
      dd = 16'(eq) * 16'(dv) + 16'(er);
      do_op(dd, dv, int'($urandom_range(0, 3)), q, r, e, lat);
      check("rand_q", 32'(q), 32'(eq));
      check("rand_r", 32'(r), 32'(er));
      check("rand_identity", 32'(16'(q) * 16'(dv) + 16'(r)), 32'(dd));
      check("rand_r_lt_div", 32'(r < dv), 32'd1);
      check("rand_lat", 32'(lat), 32'd8);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
